// File: rtl/pio_edge_irq_in_if.sv
// Avalon-MM slave bus for the edge-capturing PIO input port.
// The master drives address/strobes; the slave returns registered readdata.
interface pio_edge_irq_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_edge_irq_in.sv
// Debounced, edge-capturing PIO input port for pushbuttons/switches with a
// maskable level interrupt. Registers: DATA, reserved, IRQMASK, EDGECAPTURE (W1C).
module pio_edge_irq_in #(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    pio_edge_irq_in_if.slave    bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);

    localparam int unsigned     DB_LEN   = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES : 1;
    localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DB_LEN - 1);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;

    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;

    logic             wr_en;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] clear_w;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= IDLE_VEC;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // A differing level is accepted on the DB_LEN-th consecutive cycle it is seen;
    // any return to the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_TC) begin
                    stable_d[i] = sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_q <= IDLE_VEC;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    always_comb begin
        edge_hit = rise | fall;
        if (EDGE_TYPE == 0) begin
            edge_hit = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = fall;
        end
    end

    assign wr_en   = bus.chipselect & ~bus.write_n;
    assign wdata_w = bus.writedata[WIDTH-1:0];
    assign clear_w = (wr_en && bus.address == ADDR_EDGECAP) ? wdata_w : '0;

    // A new edge wins over a simultaneous clear so no event is ever lost.
    always_comb begin
        irqmask_d = irqmask_q;
        if (wr_en && bus.address == ADDR_IRQMASK) begin
            irqmask_d = wdata_w;
        end
        edgecap_d = (edgecap_q & ~clear_w) | edge_hit;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux = 32'(stable_q);
            ADDR_IRQMASK: rd_mux = 32'(irqmask_q);
            ADDR_EDGECAP: rd_mux = 32'(edgecap_q);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |(edgecap_q & irqmask_q);

    // Bits of writedata above WIDTH have no destination.
    assign unused_wdata = ^bus.writedata;

endmodule

// File: tb/tb_pio_edge_irq_in.sv
// Scoreboard bench for pio_edge_irq_in: dut_a is the debounced falling-edge
// build, dut_b the bypassed any-edge build.
module tb_pio_edge_irq_in;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       irq_a;
    logic       irq_b;

    int n_checks;
    int n_errors;

    logic [31:0] qa_data [$];
    bit          qa_ci   [$];
    bit          qa_ei   [$];
    string       qa_name [$];
    logic [31:0] qb_data [$];
    bit          qb_ci   [$];
    bit          qb_ei   [$];
    string       qb_name [$];

    logic [3:0] stim_b [16];
    logic [3:0] exp_b  [16];

    bit fire_a;
    bit fire_b;

    pio_edge_irq_in_if bus_a ();
    pio_edge_irq_in_if bus_b ();

    pio_edge_irq_in #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_a), .irq(irq_a)
    );

    pio_edge_irq_in #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_b), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int d, input logic [31:0] e, input bit ci, input bit ei, input string nm);
        if (d == 0) begin
            qa_data.push_back(e); qa_ci.push_back(ci); qa_ei.push_back(ei); qa_name.push_back(nm);
        end else begin
            qb_data.push_back(e); qb_ci.push_back(ci); qb_ei.push_back(ei); qb_name.push_back(nm);
        end
    endtask

    task automatic drive(input int d, input logic [1:0] a, input logic wn, input logic [31:0] wd);
        bus_a.chipselect = (d == 0); bus_a.address = a; bus_a.write_n = wn; bus_a.writedata = wd;
        bus_b.chipselect = (d == 1); bus_b.address = a; bus_b.write_n = wn; bus_b.writedata = wd;
    endtask

    task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e,
                      input bit ci, input bit ei, input string nm);
        drive(d, a, 1'b1, 32'h0);
        push(d, e, ci, ei, nm);
        @(negedge clk);
    endtask

    // A write also returns the pre-write contents of the addressed register.
    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] wd, input logic [31:0] old,
                      input bit ci, input bit ei, input string nm);
        drive(d, a, 1'b0, wd);
        push(d, old, ci, ei, nm);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(2, 2'd0, 1'b1, 32'h0);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_one(input int d);
        logic [31:0] e;
        logic [31:0] got;
        bit ci, ei, gi;
        string nm;
        n_checks++;
        if ((d == 0 && qa_data.size() == 0) || (d == 1 && qb_data.size() == 0)) begin
            n_errors++;
            $display("FAIL unexpected_response dut%0d: queue size 0, required at least 1", d);
            return;
        end
        if (d == 0) begin
            e = qa_data.pop_front(); ci = qa_ci.pop_front(); ei = qa_ei.pop_front(); nm = qa_name.pop_front();
            got = bus_a.readdata; gi = irq_a;
        end else begin
            e = qb_data.pop_front(); ci = qb_ci.pop_front(); ei = qb_ei.pop_front(); nm = qb_name.pop_front();
            got = bus_b.readdata; gi = irq_b;
        end
        if (got !== e) begin
            n_errors++;
            $display("FAIL %s dut%0d readdata: got %h, required %h", nm, d, got, e);
        end
        if (ci) begin
            n_checks++;
            if (gi !== ei) begin
                n_errors++;
                $display("FAIL %s dut%0d irq: got %b, required %b", nm, d, gi, ei);
            end
        end
    endtask

    // Monitor: any cycle with chipselect yields readdata after the edge.
    always begin
        @(posedge clk);
        fire_a = bus_a.chipselect;
        fire_b = bus_b.chipselect;
        @(negedge clk);
        if (fire_a) check_one(0);
        if (fire_b) check_one(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        stim_b = '{4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF, 4'hF, 4'hF,
                   4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF, 4'hF, 4'hF};
        exp_b  = '{4'hF, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF,
                   4'hF, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF};
        reset_n = 1'b0;
        in_a = 4'h0;
        in_b = 4'hF;
        drive(2, 2'd0, 1'b1, 32'h0);

        // Reset, then all-low inputs settle after sync + debounce.
        repeat (3) rd(0, 2'd0, 32'h0, 1, 0, "reset_readdata");
        reset_n = 1'b1;
        repeat (6) rd(0, 2'd0, 32'hF, 0, 0, "data_idle_after_reset");
        rd(0, 2'd0, 32'h0, 0, 0, "data_low_after_reset");
        rd(0, 2'd3, 32'hF, 1, 0, "edgecap_after_reset");
        in_a = 4'hF;
        wr(0, 2'd3, 32'hF, 32'hF, 0, 0, "edgecap_clear_all");
        idle(8);
        rd(0, 2'd3, 32'h0, 0, 0, "edgecap_cleared");
        rd(0, 2'd0, 32'hF, 0, 0, "data_back_high");

        // 3-cycle glitch rejected.
        in_a = 4'hE;
        repeat (3) rd(0, 2'd0, 32'hF, 0, 0, "glitch_data");
        in_a = 4'hF;
        repeat (6) rd(0, 2'd0, 32'hF, 0, 0, "glitch_data_after");
        rd(0, 2'd3, 32'h0, 0, 0, "glitch_no_capture");

        // Held low: stable at edge 6, visible in readdata at edge 7.
        in_a = 4'hE;
        repeat (6) rd(0, 2'd0, 32'hF, 0, 0, "accept_data_before");
        rd(0, 2'd0, 32'hE, 0, 0, "accept_data");
        rd(0, 2'd3, 32'h1, 1, 0, "accept_capture");

        // Interrupt mask.
        wr(0, 2'd2, 32'h2, 32'h0, 1, 0, "mask_other_bit");
        rd(0, 2'd2, 32'h2, 1, 0, "mask_readback");
        wr(0, 2'd2, 32'h1, 32'h2, 1, 1, "mask_enable_irq");
        rd(0, 2'd2, 32'h1, 1, 1, "mask_irq_held");

        // W1C of one bit out of two.
        in_a = 4'hC;
        repeat (6) rd(0, 2'd3, 32'h1, 1, 1, "bit1_pending");
        rd(0, 2'd3, 32'h3, 1, 1, "bit1_captured");
        wr(0, 2'd3, 32'h2, 32'h3, 1, 1, "w1c_bit1");
        rd(0, 2'd3, 32'h1, 1, 1, "w1c_bit1_result");

        // Clear racing a fresh falling edge on bit 0: the set wins.
        in_a = 4'hF;
        idle(7);
        in_a = 4'hE;
        idle(5);
        wr(0, 2'd3, 32'h1, 32'h1, 1, 1, "w1c_vs_edge");
        rd(0, 2'd3, 32'h1, 1, 1, "w1c_vs_edge_result");

        // Register decode.
        rd(0, 2'd1, 32'h0, 0, 0, "reserved_read");
        wr(0, 2'd1, 32'hFFFF_FFFF, 32'h0, 0, 0, "reserved_write");
        rd(0, 2'd1, 32'h0, 0, 0, "reserved_after_write");
        wr(0, 2'd2, 32'hFFFF_FFFF, 32'h1, 1, 1, "mask_write_all");
        rd(0, 2'd2, 32'hF, 1, 1, "mask_upper_bits_zero");
        wr(0, 2'd0, 32'h0, 32'hE, 0, 0, "data_write_ignored");
        rd(0, 2'd0, 32'hE, 0, 0, "data_after_write");
        wr(0, 2'd3, 32'hF, 32'h1, 1, 0, "clear_drops_irq");
        rd(0, 2'd3, 32'h0, 1, 0, "clear_result");

        // Reset during a pending debounce discards it.
        in_a = 4'hC;
        idle(4);
        reset_n = 1'b0;
        in_a = 4'hF;
        idle(2);
        reset_n = 1'b1;
        idle(10);
        rd(0, 2'd3, 32'h0, 1, 0, "midreset_no_capture");
        rd(0, 2'd0, 32'hF, 0, 0, "midreset_data");
        rd(0, 2'd2, 32'h0, 0, 0, "midreset_mask");

        // Bypass, any edge: readdata shows the input from 3 cycles earlier.
        wr(1, 2'd2, 32'h2, 32'h0, 1, 0, "b_mask");
        for (int i = 0; i < 16; i++) begin
            in_b = stim_b[i];
            rd(1, 2'd0, {28'h0, exp_b[i]}, 0, 0, "b_follow");
        end
        idle(2);
        wr(1, 2'd3, 32'hF, 32'h2, 1, 0, "b_clear");
        rd(1, 2'd3, 32'h0, 1, 0, "b_cleared");
        in_b = 4'hD;
        repeat (3) rd(1, 2'd3, 32'h0, 0, 0, "b_fall_pending");
        rd(1, 2'd3, 32'h2, 1, 1, "b_fall_captured");
        wr(1, 2'd3, 32'h2, 32'h2, 1, 0, "b_clear_again");
        in_b = 4'hF;
        repeat (3) rd(1, 2'd3, 32'h0, 0, 0, "b_rise_pending");
        rd(1, 2'd3, 32'h2, 1, 1, "b_rise_captured");

        idle(3);
        n_checks++;
        if (qa_data.size() != 0 || qb_data.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d/%0d responses outstanding, required 0/0",
                     qa_data.size(), qb_data.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
